// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the EX-stage divider.
package div_unit_pkg;

  localparam int unsigned DivDw         = 32;
  localparam int unsigned DivCntw       = 6;
  localparam int unsigned DoubleRegBusW = 2 * DivDw;

  typedef logic [DoubleRegBusW-1:0] double_reg_bus_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_if #(
  parameter int unsigned DW = 32
);
  logic              signed_div_i;
  logic [DW-1:0]     opdata1_i;
  logic [DW-1:0]     opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [2*DW-1:0]   result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multicycle radix-2 restoring divider for DIV/DIVU, result = {remainder, quotient}.
// Build option: define DIV_ANNUL_EN to let annul_i abort an in-flight divide;
// otherwise annul_i is ignored and every divide runs to completion.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DW   = DivDw,
  parameter int unsigned CNTW = DivCntw
) (
  input  logic clk,
  input  logic rst,
  div_if.slave div
);

  div_state_e        state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2*DW:0]     sr_q, sr_d;
  logic [DW-1:0]     op2_q, op2_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              ready_q, ready_d;
  logic [2*DW-1:0]   result_q, result_d;

  logic              annul;
  logic [DW-1:0]     op1_abs, op2_abs;
  logic [DW:0]       diff;
  logic [2*DW:0]     sr_step;
  logic [DW-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;

`ifdef DIV_ANNUL_EN
  assign annul = div.annul_i;
`else
  assign annul = 1'b0;
`endif

  // Operand magnitudes, one restoring step, and sign fix-up of the final step's output
  always_comb begin
    op1_abs = (div.signed_div_i && div.opdata1_i[DW-1]) ? -div.opdata1_i : div.opdata1_i;
    op2_abs = (div.signed_div_i && div.opdata2_i[DW-1]) ? -div.opdata2_i : div.opdata2_i;
    diff    = sr_q[2*DW:DW] - {1'b0, op2_q};
    // Negative trial: keep the partial remainder; otherwise replace it with diff
    sr_step = diff[DW] ? {sr_q[2*DW-1:0], 1'b0} : {diff[DW-1:0], sr_q[DW-1:0], 1'b1};
    quo_raw = sr_step[DW-1:0];
    rem_raw = sr_step[2*DW:DW+1];
    quo_fix = neg_quo_q ? -quo_raw : quo_raw;
    rem_fix = neg_rem_q ? -rem_raw : rem_raw;
  end

  // Next-state and output-register logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    op2_d     = op2_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = ready_q;
    result_d  = result_q;
    unique case (state_q)
      DivFree: begin
        if (div.start_i == DivStart && !annul) begin
          if (div.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            sr_d      = {{DW{1'b0}}, op1_abs, 1'b0};
            op2_d     = op2_abs;
            neg_quo_d = div.signed_div_i && (div.opdata1_i[DW-1] ^ div.opdata2_i[DW-1]);
            neg_rem_d = div.signed_div_i && div.opdata1_i[DW-1];
          end
        end
      end
      DivByZero: begin
        if (annul) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          ready_d  = DivResultReady;
          result_d = '0;
        end
      end
      DivOn: begin
        if (annul) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else begin
          sr_d  = sr_step;
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(DW - 1)) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      DivEnd: begin
        if (annul || div.start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  // State, counter, working and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      sr_q      <= '0;
      op2_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= DivResultNotReady;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      op2_q     <= op2_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign div.ready_o  = ready_q;
  assign div.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit. Edge counts include E0, the edge that samples start_i,
// so a normal divide shows ready after 33 edges (E0+32) and divide-by-zero after 2.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;

  div_if #(.DW(DW)) bus ();

  div_unit #(.DW(DW), .CNTW(6)) dut (
    .clk (clk),
    .rst (rst),
    .div (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide, scramble the operands after E0, count edges to ready, then release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_edges, input logic [63:0] exp_res);
    int n;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = 32'h0;
        bus.signed_div_i = ~sgn;
      end
    end while (!bus.ready_o && n < 60);
    check({tag, " edges"}, 64'(n), 64'(exp_edges));
    check({tag, " result"}, bus.result_o, exp_res);
    @(posedge clk);
    #1;
    check({tag, " held"}, {bus.result_o[62:0], bus.ready_o}, {exp_res[62:0], 1'b1});
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " release"}, {bus.result_o[62:0], bus.ready_o}, 64'h0);
  endtask

  initial begin
    int n;
    logic seen;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(bus.ready_o), 64'h0);
    check("reset result", bus.result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7 = 14 r 2
    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    // -7 / 2 = -3 r -1
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    // 7 / -2 = -3 r 1 (truncating division)
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
    // -100 / -7 = 14 r -2
    run_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'd14});
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 2, 64'h0);
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'h0, 32'hFFFF_FFFF});
    // Large unsigned divisors need the full 33-bit partial remainder
    run_div("divu max/max-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, {32'd1, 32'd1});
    run_div("divu max/8..1", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 33,
            {32'h7FFF_FFFE, 32'd1});
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});

    // Annul during iteration 10 with start still held
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
`ifdef DIV_ANNUL_EN
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | bus.ready_o;
    end
    check("annul ready never", 64'(seen), 64'h0);
    check("annul result", bus.result_o, 64'h0);
`else
    n = 11;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready_o && n < 60);
    check("annul ignored edges", 64'(n), 64'd33);
    check("annul ignored result", bus.result_o, {32'd2, 32'd14});
`endif
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul idle", {bus.result_o[62:0], bus.ready_o}, 64'h0);

    // Asynchronous reset while a result is presented
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready_o && n < 60);
    check("pre-reset ready", 64'(bus.ready_o), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst done", {bus.result_o[62:0], bus.ready_o}, 64'h0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b0;

    // Asynchronous reset mid-ON, then a fresh divide
    @(negedge clk);
    bus.start_i = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst on", {bus.result_o[62:0], bus.ready_o}, 64'h0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div("divu 9/3 after rst", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
